slot_ptr_ctrl: RTL and testbench

- Parametrised pointer and flag controller for a circular slot buffer with one writer and NUM_RD independent readers.
- Owns the registered write pointer and every read pointer. Each pointer is ADDR_W index bits plus one wrap bit.
- Produces the writer green flag (not_full), per-reader green flags (not_empty), per-reader occupancy, an almost-full warning and sticky error flags.
- Sits between the packet-slot RAM and the ingress writer / egress readers. Replaces the purely combinational flag logic driven by externally held 3-bit pointers.

---
 rtl/slot_ptr_pkg.sv | 43 ++++
 rtl/slot_rd_ptr.sv | 69 ++++++
 rtl/slot_ptr_ctrl.sv | 85 ++++++++
 tb/tb_slot_ptr_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slot_ptr_pkg.sv
// Shared pointer arithmetic for the circular slot buffer: a pointer is ADDR_W
// index bits plus one wrap bit, carried here in a fixed-width container.
package slot_ptr_pkg;

    localparam int unsigned MAX_RD = 8;
    localparam int unsigned MAX_PW = 16;

    typedef logic [MAX_PW-1:0] ptr_t;

    function automatic int unsigned ptr_w(input int unsigned addr_w);
        return addr_w + 1;
    endfunction

    function automatic ptr_t ptr_mask(input int unsigned addr_w);
        ptr_t m;
        m = '0;
        for (int unsigned b = 0; b < MAX_PW; b++) begin
            if (b <= addr_w) m[b] = 1'b1;
        end
        return m;
    endfunction

    function automatic ptr_t ptr_inc(input ptr_t p, input int unsigned addr_w);
        return (p + ptr_t'(1)) & ptr_mask(addr_w);
    endfunction

    function automatic ptr_t ptr_occ(input ptr_t wr, input ptr_t rd, input int unsigned addr_w);
        return (wr - rd) & ptr_mask(addr_w);
    endfunction

    function automatic logic ptr_empty(input ptr_t wr, input ptr_t rd, input int unsigned addr_w);
        return ((wr ^ rd) & ptr_mask(addr_w)) == '0;
    endfunction

    // Full: wrap bits differ while index bits match.
    function automatic logic ptr_full(input ptr_t wr, input ptr_t rd, input int unsigned addr_w);
        ptr_t wrap;
        wrap = '0;
        wrap[addr_w] = 1'b1;
        return ((wr ^ rd) & ptr_mask(addr_w)) == wrap;
    endfunction

endpackage

// File: rtl/slot_rd_ptr.sv
// One reader's pointer: release acceptance, mask-follow, occupancy/flags and
// sticky underflow.
module slot_rd_ptr
    import slot_ptr_pkg::*;
#(
    parameter int unsigned ADDR_W    = 2,
    parameter int unsigned AF_THRESH = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_en,
    input  logic              i_release,
    input  logic              i_err_clr,
    input  logic [ADDR_W:0]   i_wr_ptr,
    input  logic [ADDR_W:0]   i_wr_ptr_nxt,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_greenflag,
    output logic [ADDR_W:0]   o_count,
    output logic              o_full,
    output logic              o_af,
    output logic              o_udf
);

    localparam int unsigned     PW   = ptr_w(ADDR_W);
    localparam logic [PW-1:0]   AF_T = PW'(AF_THRESH);

    logic [PW-1:0] r_rd_ptr;
    logic          r_udf;
    logic [PW-1:0] w_occ;
    logic [PW-1:0] w_rd_inc;
    logic          w_empty;
    logic          w_full;
    logic          w_accept;

    assign w_occ    = PW'(ptr_occ(ptr_t'(i_wr_ptr), ptr_t'(r_rd_ptr), ADDR_W));
    assign w_rd_inc = PW'(ptr_inc(ptr_t'(r_rd_ptr), ADDR_W));
    assign w_empty  = ptr_empty(ptr_t'(i_wr_ptr), ptr_t'(r_rd_ptr), ADDR_W);
    assign w_full   = ptr_full(ptr_t'(i_wr_ptr), ptr_t'(r_rd_ptr), ADDR_W);
    assign w_accept = i_release & i_en & ~w_empty;

    // A masked reader tracks the post-commit write pointer so it re-enters empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
        end else if (!i_en) begin
            r_rd_ptr <= i_wr_ptr_nxt;
        end else if (w_accept) begin
            r_rd_ptr <= w_rd_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_udf <= 1'b0;
        end else if (i_release && !w_accept) begin
            r_udf <= 1'b1;
        end else if (i_err_clr) begin
            r_udf <= 1'b0;
        end
    end

    assign o_addr      = r_rd_ptr[ADDR_W-1:0];
    assign o_greenflag = i_en & ~w_empty;
    assign o_count     = i_en ? w_occ : '0;
    assign o_full      = i_en & w_full;
    assign o_af        = i_en & (w_occ >= AF_T);
    assign o_udf       = r_udf;

endmodule

// File: rtl/slot_ptr_ctrl.sv
// Pointer and flag controller for a circular slot buffer with one writer and
// NUM_RD independent readers.
module slot_ptr_ctrl
    import slot_ptr_pkg::*;
#(
    parameter int unsigned ADDR_W    = 2,
    parameter int unsigned NUM_RD    = 2,
    parameter int unsigned AF_THRESH = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_commit,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic                         wr_greenflag,
    output logic                         wr_almost_full,
    input  logic [NUM_RD-1:0]            rd_en_mask,
    input  logic [NUM_RD-1:0]            rd_release,
    output logic [NUM_RD*ADDR_W-1:0]     rd_addr,
    output logic [NUM_RD-1:0]            rd_greenflag,
    output logic [NUM_RD*(ADDR_W+1)-1:0] rd_count,
    input  logic                         err_clr,
    output logic                         wr_ovf,
    output logic [NUM_RD-1:0]            rd_udf
);

    localparam int unsigned PW = ptr_w(ADDR_W);

    logic [PW-1:0]     r_wr_ptr;
    logic              r_wr_ovf;
    logic [PW-1:0]     w_wr_inc;
    logic [PW-1:0]     w_wr_ptr_nxt;
    logic              w_wr_accept;
    logic [NUM_RD-1:0] w_rd_full;
    logic [NUM_RD-1:0] w_rd_af;

    assign w_wr_inc     = PW'(ptr_inc(ptr_t'(r_wr_ptr), ADDR_W));
    assign w_wr_accept  = wr_commit & wr_greenflag;
    assign w_wr_ptr_nxt = w_wr_accept ? w_wr_inc : r_wr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
        end
    end

    // A rejected commit in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ovf <= 1'b0;
        end else if (wr_commit && !wr_greenflag) begin
            r_wr_ovf <= 1'b1;
        end else if (err_clr) begin
            r_wr_ovf <= 1'b0;
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        slot_rd_ptr #(
            .ADDR_W    (ADDR_W),
            .AF_THRESH (AF_THRESH)
        ) u_rd (
            .clk          (clk),
            .rst_n        (rst_n),
            .i_en         (rd_en_mask[g]),
            .i_release    (rd_release[g]),
            .i_err_clr    (err_clr),
            .i_wr_ptr     (r_wr_ptr),
            .i_wr_ptr_nxt (w_wr_ptr_nxt),
            .o_addr       (rd_addr[g*ADDR_W +: ADDR_W]),
            .o_greenflag  (rd_greenflag[g]),
            .o_count      (rd_count[g*PW +: PW]),
            .o_full       (w_rd_full[g]),
            .o_af         (w_rd_af[g]),
            .o_udf        (rd_udf[g])
        );
    end

    assign wr_addr        = r_wr_ptr[ADDR_W-1:0];
    assign wr_greenflag   = ~|w_rd_full;
    assign wr_almost_full = |w_rd_af;
    assign wr_ovf         = r_wr_ovf;

endmodule

// File: tb/tb_slot_ptr_ctrl.sv
// Directed bench for slot_ptr_ctrl: expectations are queued as stimulus is
// driven and checked after the following clock edge.
module tb_slot_ptr_ctrl;

    localparam int AW = 2;
    localparam int NR = 2;
    localparam int AF = 3;
    localparam int CW = AW + 1;

    localparam int S_WADDR = 0;
    localparam int S_WGRN  = 1;
    localparam int S_WAF   = 2;
    localparam int S_RGRN  = 3;
    localparam int S_RCNT  = 4;
    localparam int S_OVF   = 5;
    localparam int S_UDF   = 6;
    localparam int S_RADDR = 7;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             wr_commit = 1'b0;
    logic             err_clr = 1'b0;
    logic [NR-1:0]    rd_en_mask = '1;
    logic [NR-1:0]    rd_release = '0;
    logic [AW-1:0]    wr_addr;
    logic             wr_greenflag;
    logic             wr_almost_full;
    logic [NR*AW-1:0] rd_addr;
    logic [NR-1:0]    rd_greenflag;
    logic [NR*CW-1:0] rd_count;
    logic             wr_ovf;
    logic [NR-1:0]    rd_udf;

    slot_ptr_ctrl #(
        .ADDR_W    (AW),
        .NUM_RD    (NR),
        .AF_THRESH (AF)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_commit      (wr_commit),
        .wr_addr        (wr_addr),
        .wr_greenflag   (wr_greenflag),
        .wr_almost_full (wr_almost_full),
        .rd_en_mask     (rd_en_mask),
        .rd_release     (rd_release),
        .rd_addr        (rd_addr),
        .rd_greenflag   (rd_greenflag),
        .rd_count       (rd_count),
        .err_clr        (err_clr),
        .wr_ovf         (wr_ovf),
        .rd_udf         (rd_udf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    sig;
        int    idx;
        int    val;
        string tag;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [31:0] obs(input int sig, input int idx);
        case (sig)
            S_WADDR: return 32'(wr_addr);
            S_WGRN:  return 32'(wr_greenflag);
            S_WAF:   return 32'(wr_almost_full);
            S_RGRN:  return 32'(rd_greenflag[idx]);
            S_RCNT:  return 32'(rd_count[idx*CW +: CW]);
            S_OVF:   return 32'(wr_ovf);
            S_UDF:   return 32'(rd_udf[idx]);
            S_RADDR: return 32'(rd_addr[idx*AW +: AW]);
            default: return 'x;
        endcase
    endfunction

    task automatic want(input int sig, input int idx, input int val, input string tag);
        exp_t e;
        e.sig = sig;
        e.idx = idx;
        e.val = val;
        e.tag = tag;
        q.push_back(e);
    endtask

    task automatic check_q();
        exp_t        e;
        logic [31:0] o;
        while (q.size() > 0) begin
            e = q.pop_front();
            o = obs(e.sig, e.idx);
            total++;
            assert (o === 32'(e.val)) else begin
                bad++;
                $error("FAIL %s observed=%0d expected=%0d", e.tag, o, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check_q();
        wr_commit  = 1'b0;
        rd_release = '0;
        err_clr    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        want(S_WGRN, 0, 1, "rst_wgrn");
        want(S_WAF, 0, 0, "rst_waf");
        want(S_WADDR, 0, 0, "rst_waddr");
        want(S_OVF, 0, 0, "rst_ovf");
        for (int i = 0; i < NR; i++) begin
            want(S_RGRN, i, 0, "rst_rgrn");
            want(S_RCNT, i, 0, "rst_rcnt");
            want(S_UDF, i, 0, "rst_udf");
        end
        check_q();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // fill to full
        for (int k = 1; k <= 4; k++) begin
            wr_commit = 1'b1;
            want(S_WGRN, 0, (k < 4) ? 1 : 0, "fill_wgrn");
            want(S_WAF, 0, (k >= 3) ? 1 : 0, "fill_waf");
            tick();
        end
        want(S_RCNT, 0, 4, "fill_cnt0");
        want(S_RCNT, 1, 4, "fill_cnt1");
        want(S_WADDR, 0, 0, "fill_waddr");
        want(S_RGRN, 0, 1, "fill_rgrn0");
        want(S_RGRN, 1, 1, "fill_rgrn1");
        check_q();

        // slow reader gates the writer
        for (int k = 1; k <= 4; k++) begin
            rd_release = 2'b01;
            want(S_RCNT, 0, 4 - k, "slow_cnt0");
            want(S_WGRN, 0, 0, "slow_wgrn");
            tick();
        end
        want(S_RGRN, 0, 0, "slow_rgrn0");
        want(S_RADDR, 0, 0, "slow_raddr0");
        check_q();
        rd_release = 2'b10;
        want(S_WGRN, 0, 1, "slow_wgrn_free");
        want(S_RCNT, 1, 3, "slow_cnt1");
        want(S_RADDR, 1, 1, "slow_raddr1");
        tick();

        // refill reader1 to full, then overflow
        wr_commit = 1'b1;
        want(S_RCNT, 1, 4, "refill_cnt1");
        want(S_WGRN, 0, 0, "refill_wgrn");
        tick();
        wr_commit = 1'b1;
        want(S_OVF, 0, 1, "ovf_set");
        want(S_WADDR, 0, 1, "ovf_waddr");
        want(S_RCNT, 1, 4, "ovf_cnt1");
        tick();
        err_clr = 1'b1;
        want(S_OVF, 0, 0, "ovf_clr");
        tick();

        // commit and limiting release together at full: no bypass
        wr_commit  = 1'b1;
        rd_release = 2'b10;
        want(S_OVF, 0, 1, "sim_ovf");
        want(S_RCNT, 1, 3, "sim_cnt1");
        want(S_WADDR, 0, 1, "sim_waddr");
        want(S_RCNT, 0, 1, "sim_cnt0");
        tick();

        // drain and underflow
        rd_release = 2'b01;
        want(S_RCNT, 0, 0, "drain_cnt0");
        tick();
        for (int k = 1; k <= 3; k++) begin
            rd_release = 2'b10;
            want(S_RCNT, 1, 3 - k, "drain_cnt1");
            tick();
        end
        rd_release = 2'b10;
        want(S_UDF, 1, 1, "udf_set");
        want(S_UDF, 0, 0, "udf0_clean");
        want(S_RCNT, 1, 0, "udf_cnt1");
        tick();
        err_clr    = 1'b1;
        rd_release = 2'b10;
        want(S_UDF, 1, 1, "udf_err_wins");
        want(S_OVF, 0, 0, "clr_ovf");
        tick();
        err_clr = 1'b1;
        want(S_UDF, 1, 0, "udf_clr");
        tick();

        // commit + release from count 2 holds count
        wr_commit = 1'b1;
        tick();
        wr_commit = 1'b1;
        want(S_RCNT, 0, 2, "two_cnt0");
        want(S_RCNT, 1, 2, "two_cnt1");
        tick();
        wr_commit  = 1'b1;
        rd_release = 2'b11;
        want(S_RCNT, 0, 2, "net_cnt0");
        want(S_RCNT, 1, 2, "net_cnt1");
        want(S_WADDR, 0, 0, "net_waddr");
        tick();

        // mask reader1
        rd_en_mask = 2'b01;
        want(S_RCNT, 1, 0, "mask_cnt1");
        want(S_RGRN, 1, 0, "mask_rgrn1");
        want(S_RCNT, 0, 2, "mask_cnt0");
        want(S_WAF, 0, 0, "mask_waf");
        tick();
        for (int k = 1; k >= 0; k--) begin
            rd_release = 2'b01;
            want(S_RCNT, 0, k, "mask_drain0");
            tick();
        end
        rd_release = 2'b10;
        want(S_UDF, 1, 1, "udf_masked");
        tick();

        // wrap-around with reader1 masked
        for (int k = 1; k <= 20; k++) begin
            wr_commit = 1'b1;
            want(S_RCNT, 0, 1, "wrap_cnt0_hi");
            want(S_WGRN, 0, 1, "wrap_wgrn_c");
            want(S_WADDR, 0, k % 4, "wrap_waddr");
            tick();
            rd_release = 2'b01;
            want(S_RCNT, 0, 0, "wrap_cnt0_lo");
            want(S_WGRN, 0, 1, "wrap_wgrn_r");
            want(S_RCNT, 1, 0, "wrap_cnt1");
            tick();
        end
        want(S_OVF, 0, 0, "wrap_ovf");
        check_q();

        // re-enable reader1: starts empty
        rd_en_mask = 2'b11;
        want(S_RCNT, 1, 0, "reen_cnt1");
        want(S_RGRN, 1, 0, "reen_rgrn1");
        want(S_RADDR, 1, 0, "reen_raddr1");
        tick();
        for (int k = 1; k <= 3; k++) begin
            wr_commit = 1'b1;
            want(S_RCNT, 0, k, "occ_cnt0");
            want(S_RCNT, 1, k, "occ_cnt1");
            want(S_WAF, 0, (k == 3) ? 1 : 0, "occ_waf");
            tick();
        end

        // asynchronous reset between edges
        #3;
        rst_n = 1'b0;
        #1;
        want(S_WGRN, 0, 1, "ares_wgrn");
        want(S_WAF, 0, 0, "ares_waf");
        want(S_WADDR, 0, 0, "ares_waddr");
        want(S_UDF, 1, 0, "ares_udf1");
        for (int i = 0; i < NR; i++) begin
            want(S_RCNT, i, 0, "ares_rcnt");
            want(S_RGRN, i, 0, "ares_rgrn");
        end
        check_q();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        wr_commit = 1'b1;
        want(S_RCNT, 0, 1, "post_cnt0");
        want(S_WADDR, 0, 1, "post_waddr");
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
